// File: rtl/recip_sched_pkg.sv
// Shared types and limits for the reciprocal-significand issue scheduler.
package recip_sched_pkg;

    localparam int PIPE_MAX = 3;

    typedef logic req_id_t;

    typedef struct packed {
        logic guard;
        logic round;
        logic sticky;
    } grs_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; the priority pointer moves only on an accepted grant.
module rr_arb2
    import recip_sched_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic [1:0] i_valid,
    input  logic       i_advance,
    output logic [1:0] o_grant,
    output req_id_t    o_grant_idx
);

    req_id_t r_prio;
    req_id_t w_idx;

    // A lone requester wins outright; on a tie the pointer decides.
    always_comb begin
        w_idx = i_valid[1];
        if (i_valid == 2'b11)
            w_idx = r_prio;
    end

    assign o_grant     = i_valid & (w_idx ? 2'b10 : 2'b01);
    assign o_grant_idx = w_idx;

    // NOTE: asynchronous active-low reset sits in the sensitivity list, and
    // state is written with non-blocking assignments only.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            r_prio <= 1'b0;
        else if (i_advance)
            r_prio <= ~w_idx;
    end

endmodule

// File: rtl/recip_sched.sv
// Issue scheduler for a shared reciprocal significand datapath: arbitrates two requesters and
// tracks in-flight ownership. Define RECIP_SCHED_PERF_EN to add issue/stall performance counters.
module recip_sched
    import recip_sched_pkg::*;
#(
    parameter int SIG_WIDTH   = 23,
    parameter int PIPE_STAGES = 0
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic [1:0]                   req_valid,
    input  logic [2*(SIG_WIDTH+1)-1:0]   req_d,
    output logic [1:0]                   req_ready,
    input  logic                         flush,
    output logic [SIG_WIDTH:0]           dp_d,
    output logic                         dp_enable,
    input  logic [SIG_WIDTH:0]           dp_quotient,
    input  logic [2:0]                   dp_grs,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_id,
    output logic [SIG_WIDTH:0]           out_quotient,
    output logic [2:0]                   out_grs
`ifdef RECIP_SCHED_PERF_EN
    ,
    output logic [31:0]                  perf_issue_cnt,
    output logic [31:0]                  perf_stall_cnt
`endif
);

    localparam int STAGES = (PIPE_STAGES > PIPE_MAX) ? PIPE_MAX : PIPE_STAGES;

    logic [1:0] w_grant;
    req_id_t    w_idx;
    logic       w_issue;
    grs_t       w_grs;

    rr_arb2 u_arb (
        .clk         (clk),
        .resetn      (resetn),
        .i_valid     (req_valid),
        .i_advance   (w_issue),
        .o_grant     (w_grant),
        .o_grant_idx (w_idx)
    );

    assign req_ready = w_grant & {2{dp_enable & !flush}};
    assign w_issue   = |(req_valid & req_ready);

    always_comb begin
        dp_d = '0;
        if (|req_valid)
            dp_d = w_idx ? req_d[2*(SIG_WIDTH+1)-1:SIG_WIDTH+1] : req_d[SIG_WIDTH:0];
    end

    assign w_grs        = dp_grs;
    assign out_grs      = w_grs;
    assign out_quotient = dp_quotient;

    if (STAGES == 0) begin : g_comb
        assign out_valid = w_issue;
        assign out_id    = w_idx;
        assign dp_enable = out_ready;
    end else begin : g_pipe
        logic    [STAGES:1] r_vld;
        req_id_t [STAGES:1] r_id;

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                r_vld <= '0;
                r_id  <= '0;
            end else begin
                if (dp_enable) begin
                    r_vld[1] <= w_issue;
                    r_id[1]  <= w_idx;
                    for (int k = 2; k <= STAGES; k++) begin
                        r_vld[k] <= r_vld[k-1];
                        r_id[k]  <= r_id[k-1];
                    end
                end
                // Flush is written last so it overrides any shift in the same cycle.
                if (flush)
                    r_vld <= '0;
            end
        end

        assign out_valid = r_vld[STAGES] & !flush;
        assign out_id    = r_id[STAGES];
        assign dp_enable = !out_valid | out_ready;
    end

`ifdef RECIP_SCHED_PERF_EN
    logic [31:0] r_perf_issue;
    logic [31:0] r_perf_stall;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_perf_issue <= '0;
            r_perf_stall <= '0;
        end else begin
            if (w_issue && r_perf_issue != '1)
                r_perf_issue <= r_perf_issue + 32'd1;
            if (out_valid && !out_ready && r_perf_stall != '1)
                r_perf_stall <= r_perf_stall + 32'd1;
        end
    end

    assign perf_issue_cnt = r_perf_issue;
    assign perf_stall_cnt = r_perf_stall;
`endif

endmodule

// File: tb/tb_recip_sched.sv
// Bench for recip_sched: three instances (PIPE_STAGES 0, 2, 3) share stimulus; each has a
// reciprocal datapath stub and an in-order flight-list model checked every cycle.
module tb_recip_sched;

    localparam int W = 23;
    localparam int N = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn, flush, out_ready;
    logic [1:0]  req_valid;
    logic [47:0] req_d;

    logic [1:0]  rr  [N];
    logic        dpe [N];
    logic        ov  [N];
    logic        oid [N];
    logic [23:0] dpd [N];
    logic [23:0] dpq [N];
    logic [23:0] oq  [N];
    logic [2:0]  dpg [N];
    logic [2:0]  og  [N];
`ifdef RECIP_SCHED_PERF_EN
    logic [31:0] pic [N];
    logic [31:0] psc [N];
`endif

    int total = 0;
    int bad   = 0;

    function automatic int pv(int i);
        return (i == 0) ? 0 : (i == 1) ? 2 : 3;
    endfunction

    // Reciprocal of a normalised significand: 24-bit quotient plus guard/round/sticky.
    function automatic logic [26:0] recip(logic [23:0] d);
        logic [63:0] num;
        logic [63:0] q;
        logic [63:0] r;
        if (!d[23])
            return 27'd0;
        if (d == 24'h800000)
            return {24'h800000, 3'b000};
        num = 64'd1 << 50;
        q   = num / {40'd0, d};
        r   = num % {40'd0, d};
        return {q[26:3], q[2], q[1], q[0] | (r != 64'd0)};
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int P = (g == 0) ? 0 : (g == 1) ? 2 : 3;

        recip_sched #(.SIG_WIDTH(W), .PIPE_STAGES(P)) u_dut (
            .clk          (clk),
            .resetn       (resetn),
            .req_valid    (req_valid),
            .req_d        (req_d),
            .req_ready    (rr[g]),
            .flush        (flush),
            .dp_d         (dpd[g]),
            .dp_enable    (dpe[g]),
            .dp_quotient  (dpq[g]),
            .dp_grs       (dpg[g]),
            .out_valid    (ov[g]),
            .out_ready    (out_ready),
            .out_id       (oid[g]),
            .out_quotient (oq[g]),
            .out_grs      (og[g])
`ifdef RECIP_SCHED_PERF_EN
            ,
            .perf_issue_cnt (pic[g]),
            .perf_stall_cnt (psc[g])
`endif
        );

        if (P == 0) begin : g_dp0
            assign {dpq[g], dpg[g]} = recip(dpd[g]);
        end else begin : g_dpn
            logic [26:0] st [1:P];
            always @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    for (int k = 1; k <= P; k++) st[k] <= '0;
                end else if (dpe[g]) begin
                    st[1] <= recip(dpd[g]);
                    for (int k = 2; k <= P; k++) st[k] <= st[k-1];
                end
            end
            assign {dpq[g], dpg[g]} = st[P];
        end
    end

    // Reference model: ordered list of in-flight requests, each aged by pipeline advances.
    typedef struct packed {
        logic        id;
        logic [23:0] d;
        logic [3:0]  adv;
    } item_t;

    item_t fl [N][4];
    int    fn [N];
    logic  m_last [N];
    int    m_ic [N];
    int    m_sc [N];

    task automatic check(string name, int i, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s (P=%0d) got %h expected %h at %0t", name, pv(i), act, exp, $time);
        end
    endtask

    task automatic model_step(int i);
        int          p;
        logic        g_idx, any, e_en, e_ov, e_iss, e_oid;
        logic [1:0]  e_rr;
        logic [23:0] e_dpd;
        logic [26:0] e_res;
        p = pv(i);
        if (!resetn) begin
            fn[i] = 0; m_last[i] = 1'b1; m_ic[i] = 0; m_sc[i] = 0;
        end
        any   = |req_valid;
        g_idx = (req_valid == 2'b11) ? !m_last[i] : req_valid[1];
        e_dpd = any ? (g_idx ? req_d[47:24] : req_d[23:0]) : 24'd0;
        e_ov  = 1'b0;
        if (p == 0) begin
            e_en = out_ready;
        end else begin
            e_ov = !flush && fn[i] > 0 && int'(fl[i][0].adv) == p;
            e_en = !e_ov || out_ready;
        end
        e_rr  = (e_en && !flush && any) ? (g_idx ? 2'b10 : 2'b01) : 2'b00;
        e_iss = (e_rr != 2'b00);
        if (p == 0) begin
            e_ov  = e_iss;
            e_oid = g_idx;
            e_res = recip(e_dpd);
        end else begin
            e_oid = fl[i][0].id;
            e_res = recip(fl[i][0].d);
        end

        check("req_ready", i, {30'd0, rr[i]}, {30'd0, e_rr});
        check("dp_enable", i, {31'd0, dpe[i]}, {31'd0, e_en});
        check("dp_d", i, {8'd0, dpd[i]}, {8'd0, e_dpd});
        check("out_valid", i, {31'd0, ov[i]}, {31'd0, e_ov});
        if (e_ov) begin
            check("out_id", i, {31'd0, oid[i]}, {31'd0, e_oid});
            check("out_result", i, {5'd0, oq[i], og[i]}, {5'd0, e_res});
        end
`ifdef RECIP_SCHED_PERF_EN
        check("perf_issue", i, pic[i], m_ic[i]);
        check("perf_stall", i, psc[i], m_sc[i]);
`endif

        if (resetn) begin
            if (e_iss) begin
                m_last[i] = g_idx;
                m_ic[i]++;
            end
            if (e_ov && !out_ready) m_sc[i]++;
            if (p > 0) begin
                if (flush) begin
                    fn[i] = 0;
                end else if (e_en) begin
                    if (e_ov) begin
                        for (int k = 1; k < fn[i]; k++) fl[i][k-1] = fl[i][k];
                        fn[i]--;
                    end
                    for (int k = 0; k < fn[i]; k++) fl[i][k].adv = fl[i][k].adv + 4'd1;
                    if (e_iss) begin
                        fl[i][fn[i]] = '{id: g_idx, d: e_dpd, adv: 4'd1};
                        fn[i]++;
                    end
                end
            end
        end
    endtask

    task automatic settle();
        @(negedge clk);
        for (int i = 0; i < N; i++) model_step(i);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        settle();
        adv();
    endtask

    initial begin
        resetn = 1'b0; flush = 1'b0; out_ready = 1'b1; req_valid = 2'b00; req_d = '0;
        for (int i = 0; i < N; i++) begin
            fn[i] = 0; m_last[i] = 1'b1; m_ic[i] = 0; m_sc[i] = 0;
        end

        // Pin the reciprocal model with hand-computed values.
        check("pin_recip_1p0", 0, {5'd0, recip(24'h800000)}, 32'h0400_0000);
        check("pin_recip_1p5", 0, {5'd0, recip(24'hC00000)}, 32'h0555_5555);

        settle();
        for (int i = 0; i < N; i++) begin
            check("reset_out_valid", i, {31'd0, ov[i]}, 32'd0);
            check("reset_dp_enable", i, {31'd0, dpe[i]}, 32'd1);
        end
        adv();
        tick();
        resetn = 1'b1;

        // Single operand from requester 0 through the 3-stage instance.
        req_valid = 2'b01; req_d = {24'hC00000, 24'h800000};
        settle();
        check("lone_grant", 2, {30'd0, rr[2]}, 32'd1);
        adv();
        req_valid = 2'b00;
        tick();
        settle();
        check("p3_not_yet", 2, {31'd0, ov[2]}, 32'd0);
        adv();
        settle();
        check("p3_latency", 2, {31'd0, ov[2]}, 32'd1);
        check("p3_id", 2, {31'd0, oid[2]}, 32'd0);
        check("p3_quot", 2, {8'd0, oq[2]}, 32'h0080_0000);
        adv();

        // Fresh reset, then both requesters contend for four cycles.
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        req_d = {24'hC00000, 24'h900000};
        for (int j = 0; j < 8; j++) begin
            req_valid = (j < 4) ? 2'b11 : 2'b00;
            settle();
            if (j < 4)
                check("rr_grant", 2, {30'd0, rr[2]}, (j % 2 == 1) ? 32'd2 : 32'd1);
            if (j >= 3 && j <= 6) begin
                check("rr_out_valid", 2, {31'd0, ov[2]}, 32'd1);
                check("rr_out_id", 2, {31'd0, oid[2]}, (j % 2 == 0) ? 32'd1 : 32'd0);
            end
            adv();
        end

        // Fill the 2-stage pipe, stall the consumer for five cycles, then drain.
        req_valid = 2'b11;
        for (int j = 0; j < 3; j++) begin
            req_d = {1'b1, 23'($urandom), 1'b1, 23'($urandom)};
            tick();
        end
        out_ready = 1'b0;
        for (int j = 0; j < 5; j++) begin
            settle();
            check("stall_dp_enable", 1, {31'd0, dpe[1]}, 32'd0);
            check("stall_req_ready", 1, {30'd0, rr[1]}, 32'd0);
            adv();
        end
        out_ready = 1'b1; req_valid = 2'b00;
        for (int j = 0; j < 2; j++) begin
            settle();
            check("drain_valid", 1, {31'd0, ov[1]}, 32'd1);
            adv();
        end
        repeat (3) tick();

        // Flush with operations in flight, then a clean issue afterwards.
        req_valid = 2'b11;
        repeat (3) tick();
        flush = 1'b1;
        settle();
        check("flush_out_valid", 2, {31'd0, ov[2]}, 32'd0);
        check("flush_req_ready", 2, {30'd0, rr[2]}, 32'd0);
        adv();
        flush = 1'b0; req_valid = 2'b00;
        for (int j = 0; j < 3; j++) begin
            settle();
            check("post_flush_idle", 2, {31'd0, ov[2]}, 32'd0);
            adv();
        end
        req_valid = 2'b10; req_d = {24'hC00000, 24'h800000};
        tick();
        req_valid = 2'b00;
        repeat (2) tick();
        settle();
        check("post_flush_valid", 2, {31'd0, ov[2]}, 32'd1);
        check("post_flush_id", 2, {31'd0, oid[2]}, 32'd1);
        check("post_flush_quot", 2, {8'd0, oq[2]}, 32'h00AA_AAAA);
        adv();

        // Zero-stage instance with the consumer toggling every cycle.
        for (int j = 0; j < 16; j++) begin
            out_ready = j[0];
            req_valid = 2'($urandom_range(1, 3));
            req_d = {1'b1, 23'($urandom), 1'b1, 23'($urandom)};
            settle();
            check("p0_ready_mirror", 0, {31'd0, |rr[0]}, {31'd0, out_ready});
            check("p0_same_cycle", 0, {31'd0, ov[0]}, {31'd0, out_ready});
            adv();
        end

        // Reset with two operations in flight.
        out_ready = 1'b1; req_valid = 2'b01;
        repeat (2) tick();
        resetn = 1'b0; req_valid = 2'b00;
        #1;
        for (int i = 0; i < N; i++) begin
            check("reset_kill_valid", i, {31'd0, ov[i]}, 32'd0);
`ifdef RECIP_SCHED_PERF_EN
            check("reset_perf_issue", i, pic[i], 32'd0);
            check("reset_perf_stall", i, psc[i], 32'd0);
`endif
        end
        tick();
        resetn = 1'b1;

        // Randomised traffic with back-pressure, flushes and occasional resets.
        for (int j = 0; j < 3000; j++) begin
            req_valid = 2'($urandom);
            req_d     = {1'b1, 23'($urandom), 1'b1, 23'($urandom)};
            out_ready = ($urandom % 4) != 0;
            flush     = ($urandom % 32) == 0;
            resetn    = ($urandom % 400) != 0;
            tick();
        end
        resetn = 1'b1; flush = 1'b0; req_valid = 2'b00; out_ready = 1'b1;
        repeat (4) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/recip_sched.md
RECIP_SCHED -- requirements
Module: recip_sched

Interface
REQ-001 Parameter SIG_WIDTH, default 23: significand fraction width; operands and quotient are SIG_WIDTH+1 bits.
REQ-002 Parameter PIPE_STAGES, default 0: register stages in the attached reciprocal significand datapath; legal values 0..3.
REQ-003 clk  in  1  clock; all state changes on the rising edge.
REQ-004 resetn  in  1  reset, asynchronous, active-low.
REQ-005 req_valid  in  2  per-requester operand valid.
REQ-006 req_d  in  2x(SIG_WIDTH+1)  per-requester divisor significand, hidden bit set.
REQ-007 req_ready  out  2  per-requester accept; the transfer occurs when req_valid[i]&req_ready[i].
REQ-008 flush  in  1  synchronous: discards all in-flight operations.
REQ-009 dp_d  out  SIG_WIDTH+1  operand driven to the datapath.
REQ-010 dp_enable  out  1  datapath-wide pipeline advance.
REQ-011 dp_quotient  in  SIG_WIDTH+1  datapath quotient.
REQ-012 dp_grs  in  3  datapath guard, round and sticky bits.
REQ-013 out_valid  out  1  result valid.
REQ-014 out_ready  in  1  consumer accept.
REQ-015 out_id  out  1  index of the requester that owns the result.
REQ-016 out_quotient, out_grs  out  SIG_WIDTH+1, 3  result, passed through from dp_quotient and dp_grs.

Function
REQ-017 The block tracks in-flight operations with vld[1..PIPE_STAGES] and id[1..PIPE_STAGES], aligned with the datapath registers.
REQ-018 out_valid = vld[PIPE_STAGES] and out_id = id[PIPE_STAGES]; for PIPE_STAGES=0 they equal issue and the granted index in the same cycle.
REQ-019 dp_enable = !out_valid | out_ready for PIPE_STAGES>0; dp_enable = out_ready for PIPE_STAGES=0, so req_ready depends combinationally on out_ready.
REQ-020 Stalls are whole-pipe only: while dp_enable=0 every vld/id bit holds and no bubble is collapsed.
REQ-021 Arbitration is round-robin: a lone valid requester is granted; with both valid, the requester not granted last wins.
REQ-022 The round-robin pointer updates only on an accepted issue.
REQ-023 req_ready[i] = grant[i] & dp_enable & !flush; issue = |(req_valid & req_ready).
REQ-024 dp_d = req_d[grant index] when any requester is valid, otherwise zero.
REQ-025 When dp_enable=1: vld[1] <= issue, id[1] <= grant index, vld[k] <= vld[k-1], id[k] <= id[k-1].
REQ-026 Latency is exactly PIPE_STAGES cycles from issue to out_valid, plus one cycle per stall cycle.
REQ-027 Throughput is one issue per cycle while out_ready=1.
REQ-028 flush=1: all vld bits clear at the next edge, no issue occurs in that cycle, the pointer holds, and out_valid is forced 0 in that cycle.
REQ-029 Simultaneous flush and out_ready: flush wins, and no result is delivered.
REQ-030 Once out_valid=1, out_quotient, out_grs and out_id stay stable until accepted or flushed.

Reset
REQ-031 Reset is asynchronous and active-low: vld=0, id=0, and the pointer is set so requester 0 wins the first tie.
REQ-032 After reset: out_valid=0, req_ready=0 unless requested, dp_enable=1.
REQ-033 Reset asserted mid-operation discards every in-flight result with no partial output; the datapath registers reset in parallel on the same resetn.

Configuration
REQ-034 Macro RECIP_SCHED_PERF_EN defined: 32-bit saturating outputs perf_issue_cnt (accepted issues) and perf_stall_cnt (cycles with out_valid&!out_ready) exist and reset to 0.
REQ-035 Macro RECIP_SCHED_PERF_EN undefined: those ports and counters are absent, with no other behavioural change.

Structure
REQ-036 Package recip_sched_pkg holds the PIPE_MAX=3 constant, the req_id_t typedef (1 bit) and the grs_t packed struct {guard, round, sticky}.
REQ-037 Sub-module rr_arb2 holds the two-requester round-robin arbiter (valid, advance, grant, pointer register).
REQ-038 The scheduler instantiates no datapath; it connects to the reciprocal significand unit at the top level.

Verification
REQ-039 PIPE_STAGES=3, requester 0 only, d=0x800000, out_ready=1: out_valid rises 3 cycles after issue, out_id=0, quotient matches the 1/d model.
REQ-040 Both requesters valid for 4 cycles, out_ready=1: grants go 0,1,0,1 and out_id follows 0,1,0,1 three cycles later.
REQ-041 PIPE_STAGES=2, out_ready=0 for 5 cycles with the pipe full: dp_enable=0, req_ready=0, and out_quotient/out_id stay constant; on release two results drain back-to-back.
REQ-042 flush with 3 operations in flight: no out_valid for the following 3 cycles, and the next issue returns correctly after PIPE_STAGES cycles.
REQ-043 PIPE_STAGES=0, out_ready toggling every cycle: req_ready mirrors out_ready, and every accepted request yields out_valid in the same cycle.
REQ-044 resetn asserted with 2 operations in flight: out_valid=0 immediately, and perf counters read 0 when RECIP_SCHED_PERF_EN is defined.
